weight_loader: RTL
==================

WEIGHT_LOADER -- requirements
Module: weight_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning bits per weight word.
REQ-002 SHALL have parameter ADDR, default 4, meaning address bits per bank (depth 2**ADDR).
REQ-003 SHALL have parameter NUM, default 64, meaning number of parallel banks.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, with all state on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port start, input, 1 bit: one-cycle load request.
REQ-007 SHALL have port in_data, input, WIDTH bits: incoming weight word.
REQ-008 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-009 SHALL have port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-010 SHALL have port loaded, output, 1 bit: all NUM*2**ADDR words have been written.
REQ-011 SHALL have port address, input, ADDR bits: read address, common to all banks.
REQ-012 SHALL have port rom_out, output, unpacked array [0:NUM-1] of WIDTH bits: per-bank read data.
REQ-013 SHALL have port checksum, output, WIDTH bits: running modulo-2**WIDTH sum of accepted words.

Function
REQ-014 SHALL implement states IDLE, LOAD and DONE.
REQ-015 SHALL move from IDLE to LOAD on start=1, and from DONE to LOAD on start=1 (reload).
REQ-016 SHALL ignore start while in LOAD.
REQ-017 SHALL drive in_ready=1 only in LOAD, registered-state-derived with no combinational path from in_valid.
REQ-018 SHALL count a transfer only when in_valid and in_ready are both 1 on the same edge; in_valid outside LOAD is ignored and writes nothing.
REQ-019 SHALL write transfer k (0-based) to bank k/2**ADDR at entry k%2**ADDR, filling bank-major so bank 0 fills entries 0..15 first.
REQ-020 SHALL use two counters, wr_addr (ADDR bits) and wr_bank (clog2(NUM) bits): wr_addr wraps 15->0 and increments wr_bank on wrap.
REQ-021 SHALL, on the final transfer (wr_bank=NUM-1, wr_addr=2**ADDR-1), enter DONE on the next edge, set loaded=1 in that same cycle and return both counters to 0.
REQ-022 SHALL clear loaded and both counters, and zero checksum, on the cycle LOAD is entered.
REQ-023 SHALL provide rom_out[i] = bank i contents at address, combinationally, in every state.
REQ-024 SHALL make a word written on edge t visible on rom_out from cycle t+1.
REQ-025 SHALL hold loaded high in DONE until reset or the next start.

Reset
REQ-026 SHALL, with rst_n=0 at an edge, set state IDLE, in_ready=0, loaded=0, counters 0 and checksum 0.
REQ-027 SHALL NOT clear bank contents on reset; entries keep their last written value.
REQ-028 SHALL treat reset mid-LOAD as an abort: it returns to IDLE, and only a new start begins loading again, from bank 0, entry 0.

Configuration
REQ-029 SHALL, with WEIGHT_LOADER_CHECKSUM_EN defined, add each accepted in_data to checksum modulo 2**WIDTH, with the updated value visible the cycle after the transfer.
REQ-030 SHALL, without WEIGHT_LOADER_CHECKSUM_EN, drive checksum constant 0 and infer no adder.

Structure
REQ-031 SHALL take the state enum and the default WIDTH/ADDR/NUM constants from shared package weight_loader_pkg.
REQ-032 SHALL instantiate sub-module weight_bank NUM times via generate; each weight_bank is a 2**ADDR x WIDTH distributed array with one synchronous write port and one asynchronous read port.

Verification
REQ-033 SHALL verify full load: start, then stream words 0..1023 with in_valid held 1 -> 1024 accepted cycles, loaded=1 one cycle after the last transfer, and address=5 gives rom_out[3]=53 and rom_out[63]=1013.
REQ-034 SHALL verify backpressure gaps: in_valid toggled 1/0 during load -> entries still equal k, with loaded after 1024 transfers, not after 1024 cycles.
REQ-035 SHALL verify that in_valid=1 with no start -> in_ready=0, no bank changes and loaded stays 0.
REQ-036 SHALL verify reset abort: rst_n=0 after 100 transfers, then start and stream 1024 words of 0xFFFF -> every rom_out = 0xFFFF, and entries written before reset are overwritten.
REQ-037 SHALL verify start pulsed during LOAD at transfer 500 -> load is unaffected and counters continue to 1023.
REQ-038 SHALL verify, with WEIGHT_LOADER_CHECKSUM_EN, streaming words 0..1023 -> checksum = 523776 mod 65536 = 0xFE00; without the macro, checksum stays 0.

Source files
------------

// File: rtl/weight_loader_pkg.sv
// Shared FSM encoding and default geometry for the weight loader.
`default_nettype none

package weight_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_ADDR  = 4;
  localparam int DEF_NUM   = 64;

endpackage

`default_nettype wire

// File: rtl/weight_bank.sv
// One weight bank: 2**ADDR x WIDTH array, synchronous write, asynchronous read.
`default_nettype none

module weight_bank #(
  parameter int WIDTH = 16,
  parameter int ADDR  = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ADDR-1:0]  wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [ADDR-1:0]  rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  // No reset: contents must survive reset.
  logic [WIDTH-1:0] mem_q [2**ADDR];

  always_ff @(posedge clk) begin
    if (we) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

`default_nettype wire

// File: rtl/weight_loader.sv
// Streams NUM*2**ADDR weight words bank-major into NUM parallel banks.
// Optional running checksum enabled by defining WEIGHT_LOADER_CHECKSUM_EN.
`default_nettype none

module weight_loader
  import weight_loader_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ADDR  = DEF_ADDR,
  parameter int NUM   = DEF_NUM
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             loaded,
  input  logic [ADDR-1:0]  address,
  output logic [WIDTH-1:0] rom_out [0:NUM-1],
  output logic [WIDTH-1:0] checksum
);

  localparam int BANK_W = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM - 1);

  state_e            state_q, state_d;
  logic [ADDR-1:0]   wr_addr_q, wr_addr_d;
  logic [BANK_W-1:0] wr_bank_q, wr_bank_d;
  logic              loaded_q, loaded_d;
  logic              xfer;

  assign in_ready = (state_q == LOAD);
  assign loaded   = loaded_q;
  assign xfer     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_addr_q <= '0;
      wr_bank_q <= '0;
      loaded_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      wr_bank_q <= wr_bank_d;
      loaded_q  <= loaded_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    wr_bank_d = wr_bank_q;
    loaded_d  = loaded_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = LOAD;
          wr_addr_d = '0;
          wr_bank_d = '0;
          loaded_d  = 1'b0;
        end
      end
      LOAD: begin
        if (xfer) begin
          if (wr_addr_q == '1) begin
            wr_addr_d = '0;
            if (wr_bank_q == LAST_BANK) begin
              wr_bank_d = '0;
              state_d   = DONE;
              loaded_d  = 1'b1;
            end else begin
              wr_bank_d = wr_bank_q + 1'b1;
            end
          end else begin
            wr_addr_d = wr_addr_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The reset gate keeps a transfer coinciding with an abort from landing in a bank.
  for (genvar i = 0; i < NUM; i++) begin : g_bank
    weight_bank #(
      .WIDTH (WIDTH),
      .ADDR  (ADDR)
    ) u_bank (
      .clk     (clk),
      .we      (xfer && rst_n && (wr_bank_q == BANK_W'(i))),
      .wr_addr (wr_addr_q),
      .wr_data (in_data),
      .rd_addr (address),
      .rd_data (rom_out[i])
    );
  end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [WIDTH-1:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (start && (state_q != LOAD)) checksum_d = '0;
    else if (xfer)                  checksum_d = checksum_q + in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) checksum_q <= '0;
    else        checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

endmodule

`default_nettype wire
